// File: rtl/serial_tofed_tx.sv
// Parallel-to-serial feeder: buffers codewords in a small FIFO and shifts them out MSB-first with
// frame alignment strobes. Optional popcount monitor enabled by SERIAL_TOFED_WEIGHT_CHECK_EN.
module serial_tofed_tx #(
   parameter int FRAME_W    = 5,
   parameter int FIFO_DEPTH = 2
) (
   input  logic               clk,
   input  logic               resetH,
   input  logic [FRAME_W-1:0] in_data,
   input  logic               in_valid,
   output logic               in_ready,
   output logic               dout,
   output logic               dout_en,
   output logic               frame_start,
   output logic               busy
`ifdef SERIAL_TOFED_WEIGHT_CHECK_EN
   ,
   output logic               bad_word
`endif
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int BIT_W = $clog2(FRAME_W);

   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

   state_t               state_q, state_d;
   logic [FRAME_W-1:0]   mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]     count_q, count_d;
   logic [FRAME_W-1:0]   shreg_q, shreg_d;
   logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
   logic                 in_ready_q;
   logic                 dout_q, dout_d;
   logic                 dout_en_q, dout_en_d;
   logic                 frame_start_q, frame_start_d;

   logic push, pop, fifo_empty, last_bit;

   assign fifo_empty = (count_q == '0);
   assign last_bit   = (bit_cnt_q == BIT_W'(FRAME_W - 1));
   assign push       = in_valid && in_ready_q;
   // Back-to-back frames: the next word is loaded on the same edge that emits the last bit.
   assign pop        = !fifo_empty && ((state_q == IDLE) || last_bit);
   assign count_d    = count_q + CNT_W'(push) - CNT_W'(pop);

   // State register
   always_ff @(posedge clk or negedge resetH) begin
      if (!resetH) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (!fifo_empty) state_d = SHIFT;
         SHIFT:   if (last_bit && fifo_empty) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output logic (values registered on the next edge)
   always_comb begin
      dout_d        = 1'b0;
      dout_en_d     = 1'b0;
      frame_start_d = 1'b0;
      if (state_q == SHIFT) begin
         dout_d        = shreg_q[FRAME_W-1];
         dout_en_d     = 1'b1;
         frame_start_d = (bit_cnt_q == '0);
      end
   end

   always_comb begin
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      if (pop) begin
         shreg_d   = mem_q[rd_ptr_q];
         bit_cnt_d = '0;
      end else if (state_q == SHIFT && !last_bit) begin
         shreg_d   = {shreg_q[FRAME_W-2:0], 1'b0};
         bit_cnt_d = bit_cnt_q + BIT_W'(1);
      end
   end

   // Storage has no reset; emptiness is tracked by the pointers and count alone.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= in_data;
   end

   always_ff @(posedge clk or negedge resetH) begin
      if (!resetH) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         shreg_q       <= '0;
         bit_cnt_q     <= '0;
         in_ready_q    <= 1'b0;
         dout_q        <= 1'b0;
         dout_en_q     <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q       <= count_d;
         shreg_q       <= shreg_d;
         bit_cnt_q     <= bit_cnt_d;
         in_ready_q    <= (count_d != CNT_W'(FIFO_DEPTH));
         dout_q        <= dout_d;
         dout_en_q     <= dout_en_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign dout        = dout_q;
   assign dout_en     = dout_en_q;
   assign frame_start = frame_start_q;
   assign busy        = !fifo_empty || (state_q == SHIFT);

`ifdef SERIAL_TOFED_WEIGHT_CHECK_EN
   logic bad_word_q;

   always_ff @(posedge clk or negedge resetH) begin
      if (!resetH) bad_word_q <= 1'b0;
      else         bad_word_q <= push && ($countones(in_data) != 3);
   end

   assign bad_word = bad_word_q;
`endif

endmodule
